// File: rtl/rv_flush_tag_store_if.sv
// Flush-stream, lookup, response and fill signals of one cache tag-store bank.
// The master side is the flush controller / requester; the slave is the store.
interface rv_flush_tag_store_if #(
    parameter int LINE_SELECT_BITS = 14,
    parameter int TAG_WIDTH        = 16
);
    logic [LINE_SELECT_BITS-1:0] flush_addr;
    logic                        flush_valid;
    logic                        flush_done;
    logic                        lookup_valid;
    logic                        lookup_ready;
    logic [LINE_SELECT_BITS-1:0] lookup_line;
    logic [TAG_WIDTH-1:0]        lookup_tag;
    logic                        rsp_valid;
    logic                        rsp_hit;
    logic [TAG_WIDTH-1:0]        rsp_tag;
    logic                        fill_valid;
    logic [LINE_SELECT_BITS-1:0] fill_line;
    logic [TAG_WIDTH-1:0]        fill_tag;
    logic                        flush_err;

    modport master (
        output flush_addr, flush_valid, lookup_valid, lookup_line, lookup_tag,
               fill_valid, fill_line, fill_tag,
        input  flush_done, lookup_ready, rsp_valid, rsp_hit, rsp_tag, flush_err
    );

    modport slave (
        input  flush_addr, flush_valid, lookup_valid, lookup_line, lookup_tag,
               fill_valid, fill_line, fill_tag,
        output flush_done, lookup_ready, rsp_valid, rsp_hit, rsp_tag, flush_err
    );
endinterface

// File: rtl/rv_flush_tag_store.sv
// Tag/valid store for one cache bank. Consumes the flush sweep, clearing one
// valid bit per beat, and serves lookups and fills once every line has been
// swept. Completion is count-based.
//
// Optional macro FLUSH_ERR_CHK_EN builds a sticky checker on flush_err for
// out-of-order flush beats and fills arriving during a flush. Without it
// flush_err is tied low.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_FLUSH | sweep in progress; lookups held off, fills dropped
// S_READY | all lines invalidated; lookups and fills served
module rv_flush_tag_store #(
    parameter int CACHE_SIZE      = 16384,
    parameter int CACHE_LINE_SIZE = 1,
    parameter int NUM_BANKS       = 1,
    parameter int TAG_WIDTH       = 16
) (
    input  logic               clk,
    input  logic               reset,
    rv_flush_tag_store_if.slave bus
);
    localparam int NUM_LINES        = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS);
    localparam int LINE_SELECT_BITS = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int CNT_W            = LINE_SELECT_BITS + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_LINES - 1);

    typedef enum logic {S_FLUSH, S_READY} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic                 flush_done_c, lookup_ready_c;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_WIDTH-1:0] tag_mem [NUM_LINES];
    logic                 lookup_acc, fill_acc, flush_beat;
    logic                 rsp_valid_q, rsp_hit_q;
    logic [TAG_WIDTH-1:0] rsp_tag_q;

    assign flush_beat = bus.flush_valid && !reset;
    assign lookup_acc = bus.lookup_valid && (state_q == S_READY);
    // A flush beat in READY wins over a same-cycle fill.
    assign fill_acc   = bus.fill_valid && (state_q == S_READY) && !bus.flush_valid && !reset;

    // State and sweep-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state, counter update and status outputs.
    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        flush_done_c   = 1'b0;
        lookup_ready_c = 1'b0;
        case (state_q)
            S_FLUSH: begin
                if (bus.flush_valid) begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                    if (flush_cnt_q == LAST_CNT) begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                flush_done_c   = 1'b1;
                lookup_ready_c = 1'b1;
                // The beat that restarts the sweep already counts as line one.
                if (bus.flush_valid) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = CNT_W'(1);
                end
            end
            default: state_d = S_FLUSH;
        endcase
    end

    // Valid bits: cleared by flush beats, set by accepted fills; no reset.
    always_ff @(posedge clk) begin
        if (flush_beat) begin
            valid_q[bus.flush_addr] <= 1'b0;
        end else if (fill_acc) begin
            valid_q[bus.fill_line] <= 1'b1;
        end
    end

    // Tag array write on accepted fills; no reset.
    always_ff @(posedge clk) begin
        if (fill_acc) begin
            tag_mem[bus.fill_line] <= bus.fill_tag;
        end
    end

    // Lookup response; reads pre-update contents, so same-cycle fills are not seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_tag_q   <= '0;
        end else begin
            rsp_valid_q <= lookup_acc;
            if (lookup_acc) begin
                rsp_tag_q <= tag_mem[bus.lookup_line];
                rsp_hit_q <= valid_q[bus.lookup_line] &&
                             (tag_mem[bus.lookup_line] == bus.lookup_tag);
            end
        end
    end

`ifdef FLUSH_ERR_CHK_EN
    logic flush_err_q;

    // Sticky protocol checker: beat out of sequence, or fill during a sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_err_q <= 1'b0;
        end else if ((bus.flush_valid &&
                      (bus.flush_addr != flush_cnt_q[LINE_SELECT_BITS-1:0])) ||
                     (bus.fill_valid && (state_q == S_FLUSH))) begin
            flush_err_q <= 1'b1;
        end
    end

    assign bus.flush_err = flush_err_q;
`else
    assign bus.flush_err = 1'b0;
`endif

    assign bus.flush_done   = flush_done_c;
    assign bus.lookup_ready = lookup_ready_c;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_hit      = rsp_hit_q;
    assign bus.rsp_tag      = rsp_tag_q;
endmodule

// File: tb/tb_rv_flush_tag_store.sv
// Bench for rv_flush_tag_store: 16 lines, 8-bit tags. Directed sequences
// followed by randomized traffic, all checked against an array-based model.
module tb_rv_flush_tag_store;
    localparam int LSB = 4;
    localparam int TW  = 8;
    localparam int NL  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rv_flush_tag_store_if #(.LINE_SELECT_BITS(LSB), .TAG_WIDTH(TW)) bus ();

    rv_flush_tag_store #(
        .CACHE_SIZE(16), .CACHE_LINE_SIZE(1), .NUM_BANKS(1), .TAG_WIDTH(TW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: per-line valid/tag arrays plus sweep progress.
    bit           m_valid [NL];
    bit           m_tknown[NL];
    logic [TW-1:0] m_tag  [NL];
    bit           m_ready;
    int           m_cnt;
    bit           m_err;
    bit           e_rv, e_hit, e_tk;
    logic [TW-1:0] e_tag;

    task automatic idle();
        bus.flush_valid  = 1'b0;
        bus.flush_addr   = '0;
        bus.lookup_valid = 1'b0;
        bus.lookup_line  = '0;
        bus.lookup_tag   = '0;
        bus.fill_valid   = 1'b0;
        bus.fill_line    = '0;
        bus.fill_tag     = '0;
    endtask

    task automatic beat(int a);
        bus.flush_valid = 1'b1;
        bus.flush_addr  = LSB'(a);
    endtask

    task automatic lookup(int l, int t);
        bus.lookup_valid = 1'b1;
        bus.lookup_line  = LSB'(l);
        bus.lookup_tag   = TW'(t);
    endtask

    task automatic fill(int l, int t);
        bus.fill_valid = 1'b1;
        bus.fill_line  = LSB'(l);
        bus.fill_tag   = TW'(t);
    endtask

    // Advance model and DUT one clock, then compare all outputs.
    task automatic cycle(string ph);
        int fa, fl, ll;
        fa = int'(bus.flush_addr);
        fl = int'(bus.fill_line);
        ll = int'(bus.lookup_line);
        if (reset) begin
            m_ready = 0; m_cnt = 0; m_err = 0;
            e_rv = 0; e_hit = 0; e_tag = '0; e_tk = 1;
        end else begin
            if (m_ready && bus.lookup_valid) begin
                e_rv  = 1;
                e_hit = m_valid[ll] ? (m_tag[ll] == bus.lookup_tag) : 1'b0;
                e_tk  = m_tknown[ll];
                e_tag = m_tag[ll];
            end else begin
                e_rv = 0;
            end
`ifdef FLUSH_ERR_CHK_EN
            if (bus.flush_valid && fa != (m_cnt % NL)) m_err = 1;
            if (bus.fill_valid && !m_ready) m_err = 1;
`endif
            if (bus.flush_valid) begin
                m_valid[fa] = 0;
                if (m_ready) begin
                    m_ready = 0;
                    m_cnt   = 1;
                end else begin
                    m_cnt++;
                    if (m_cnt == NL) m_ready = 1;
                end
            end else if (bus.fill_valid && m_ready) begin
                m_valid[fl]  = 1;
                m_tag[fl]    = bus.fill_tag;
                m_tknown[fl] = 1;
            end
        end
        @(posedge clk);
        #1;
        check({ph, ".flush_done"},   32'(bus.flush_done),   32'(m_ready));
        check({ph, ".lookup_ready"}, 32'(bus.lookup_ready), 32'(m_ready));
        check({ph, ".rsp_valid"},    32'(bus.rsp_valid),    32'(e_rv));
        check({ph, ".rsp_hit"},      32'(bus.rsp_hit),      32'(e_hit));
        if (e_tk) check({ph, ".rsp_tag"}, 32'(bus.rsp_tag), 32'(e_tag));
        check({ph, ".flush_err"},    32'(bus.flush_err),    32'(m_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        int l;
        reset = 1'b1;
        idle();
        #1;
        cycle("rst");
        cycle("rst");
        check("rst.ready_const", 32'(bus.lookup_ready), 32'd0);
        check("rst.rsp_tag_const", 32'(bus.rsp_tag), 32'd0);
        reset = 1'b0;

        // 1: sequential sweep, completion the cycle after beat 15
        for (int a = 0; a < NL; a++) begin
            idle(); beat(a);
            if (a == NL - 1) check("t1.no_early_done", 32'(bus.flush_done), 32'd0);
            cycle("t1");
        end
        check("t1.done_const", 32'(bus.flush_done), 32'd1);
        idle(); lookup(3, $urandom_range(0, 255)); cycle("t1.lk");
        check("t1.miss_const", 32'(bus.rsp_hit), 32'd0);

        // 2: fill then hit / tag mismatch
        idle(); fill(5, 8'hA7); cycle("t2.fill");
        idle(); lookup(5, 8'hA7); cycle("t2.lk");
        check("t2.hit_const", 32'(bus.rsp_hit), 32'd1);
        check("t2.tag_const", 32'(bus.rsp_tag), 32'hA7);
        idle(); lookup(5, 8'hA6); cycle("t2.lk2");
        check("t2.miss_const", 32'(bus.rsp_hit), 32'd0);

        // 3: same-cycle fill and lookup reads old contents
        idle(); fill(9, 8'h3C); lookup(9, 8'h3C); cycle("t3.both");
        check("t3.rbw_const", 32'(bus.rsp_hit), 32'd0);
        idle(); lookup(9, 8'h3C); cycle("t3.again");
        check("t3.hit_const", 32'(bus.rsp_hit), 32'd1);

        // 4+5: fill line 2, re-flush with gap; lookup on first beat still hits
        idle(); fill(2, 8'h11); cycle("t5.fill");
        for (int a = 0; a < NL; a++) begin
            idle(); beat(a);
            if (a == 0) begin lookup(5, 8'hA7); fill(7, 8'h55); end
            cycle("t4");
            if (a == 0) begin
                check("t5.done_drop", 32'(bus.flush_done), 32'd0);
                check("t5.inflight_hit", 32'(bus.rsp_hit), 32'd1);
            end
            if (a == 7) begin
                for (int g = 0; g < 3; g++) begin idle(); cycle("t4.gap"); end
            end
        end
        idle(); lookup(2, 8'h11); cycle("t5.lk2");
        check("t5.miss2", 32'(bus.rsp_hit), 32'd0);
        idle(); lookup(5, 8'hA7); cycle("t5.lk5");
        check("t5.miss5", 32'(bus.rsp_hit), 32'd0);

        // 6: out-of-order beats set the sticky error when the checker is built
        reset = 1'b1; idle(); cycle("t6.rst"); reset = 1'b0;
        idle(); beat(0); cycle("t6");
        idle(); beat(1); cycle("t6");
        idle(); beat(3); cycle("t6");
`ifdef FLUSH_ERR_CHK_EN
        check("t6.err_const", 32'(bus.flush_err), 32'd1);
`else
        check("t6.err_const", 32'(bus.flush_err), 32'd0);
`endif
        for (int g = 0; g < 4; g++) begin idle(); cycle("t6.hold"); end
        reset = 1'b1; idle(); cycle("t6.rst2"); reset = 1'b0;
        check("t6.err_clr", 32'(bus.flush_err), 32'd0);
        for (int a = 0; a < NL; a++) begin idle(); beat(a); cycle("t6.sweep"); end

        // randomized traffic with re-flushes and occasional resets
        nxt = 0;
        for (int i = 0; i < 1500; i++) begin
            idle();
            if ($urandom_range(0, 1) == 1) begin
                l = $urandom_range(0, NL - 1);
                lookup(l, ($urandom_range(0, 1) == 1 && m_tknown[l]) ?
                          int'(m_tag[l]) : $urandom_range(0, 255));
            end
            if ($urandom_range(0, 3) == 0) fill($urandom_range(0, NL - 1), $urandom_range(0, 255));
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                nxt   = 0;
            end else begin
                reset = 1'b0;
                if (m_ready && $urandom_range(0, 59) == 0) begin
                    beat(0); nxt = 1;
                end else if (!m_ready && $urandom_range(0, 2) != 0) begin
                    beat(nxt); nxt++;
                end
            end
            cycle("rnd");
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
